// File: rtl/wb_uart_host_master_if.sv
// Bundles the command stream, response stream and Wishbone initiator signals
// of the UART host master.
//   master modport : the view of wb_uart_host_master (accepts commands,
//                    produces responses, drives the Wishbone cycle)
//   slave  modport : the view of the surroundings (host logic plus the
//                    UART register slave)
// Command  : cmd_valid/cmd_ready, cmd_we, cmd_addr[4:0], cmd_wdata[31:0], cmd_sel[3:0]
// Response : rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err
// Wishbone : wbm_adr_o[4:0], wbm_dat_o[31:0], wbm_sel_o[3:0], wbm_we_o,
//            wbm_cyc_o, wbm_stb_o, wbm_dat_i[31:0], wbm_ack_i
interface wb_uart_host_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [4:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_uart_host_master.sv
// Wishbone B3 classic single-access master for the UART register slave.
// Each accepted command becomes exactly one read or write cycle; the result
// (read data or timeout error) is returned on the response stream.
// Ports:
//   wb_clk_i : clock, rising edge
//   wb_rst_i : asynchronous active-high reset
//   bus      : command, response and Wishbone signals (master modport)
// Parameters:
//   TIMEOUT  : stb cycles without ack before the cycle is aborted (2..255)
//   CNT_W    : timeout counter width, 2**CNT_W > TIMEOUT
module wb_uart_host_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  wb_uart_host_master_if.master     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Held low during reset so the host cannot hand over a command that would
  // be lost when reset releases.
  assign bus.cmd_ready = (state == S_IDLE) && !wb_rst_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.wbm_adr_o <= '0;
      bus.wbm_dat_o <= '0;
      bus.wbm_sel_o <= '0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        // Command accept: the bus cycle starts at the same edge.
        S_IDLE: begin
          if (bus.cmd_valid) begin
            bus.wbm_adr_o <= bus.cmd_addr;
            bus.wbm_dat_o <= bus.cmd_wdata;
            bus.wbm_sel_o <= bus.cmd_sel;
            bus.wbm_we_o  <= bus.cmd_we;
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            cnt           <= '0;
            state         <= S_BUS;
          end
        end
        // Bus cycle in flight: an ack on the last permitted cycle still
        // counts as success, so it is tested before the timeout.
        S_BUS: begin
          if (bus.wbm_ack_i) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_rdata <= bus.wbm_we_o ? 32'h0 : bus.wbm_dat_i;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Response held until the host takes it.
        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
